serial_rx_frame: RTL and testbench

// - Serial-in/parallel-out receive stage; the downstream counterpart of the 10-bit PISO transmit shifter.
// - Frame format: start(0), DATA_BITS data bits MSB first, stop(1). The line idles high.
// - Oversamples serial_in on sample_tick, finds the mid-bit of each bit and assembles the byte.
// - Presents each byte with a valid/ready handshake and flags framing and overrun errors.

---
 rtl/serial_rx_frame.sv | 200 ++++++++++++++++++++
 tb/tb_serial_rx_frame.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_rx_frame.sv
// ---------------------------------------------------------------------------
// serial_rx_frame
//   Oversampling serial receiver. Frame: start(0), DATA_BITS data bits MSB
//   first, [even parity], stop(1). Line idles high. Each bit is sampled at
//   its middle, counted in sample_tick pulses from the start-bit edge.
//   Received words are offered on a valid/ready handshake.
//
//   Optional feature macro: PARITY_CHECK_EN
//     An even-parity bit follows the data bits. A mismatch drops the word
//     and pulses parity_err.
//
// Ports
//   clk         system clock
//   reset       synchronous, active-high
//   sample_tick one-clk enable at OVERSAMPLE x bit rate
//   serial_in   asynchronous serial line
//   data_out    received word; MSB is the first data bit on the line
//   data_valid  data_out holds an unconsumed word
//   data_ready  consumer takes the word on an edge where valid & ready
//   frame_err   one-clk pulse: stop bit sampled low
//   overrun     one-clk pulse: completed word dropped, previous not consumed
//   parity_err  (PARITY_CHECK_EN only) one-clk pulse: parity mismatch
// ---------------------------------------------------------------------------
module serial_rx_frame #(
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 sample_tick,
    input  logic                 serial_in,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 data_valid,
    input  logic                 data_ready,
    output logic                 frame_err,
    output logic                 overrun
`ifdef PARITY_CHECK_EN
    ,
    output logic                 parity_err
`endif
);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS + 2);

    // Start bit is confirmed half a bit in; every later sample is one full
    // bit after the previous one, which lands it mid-bit.
    localparam logic [TW-1:0] HALF_LAST = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] BIT_LAST  = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef PARITY_CHECK_EN
        S_PARITY,
`endif
        S_STOP,
        S_BREAK
    } state_t;

    state_t               state;
    logic [TW-1:0]        tick_cnt;
    logic [BW-1:0]        bit_cnt;
    logic [DATA_BITS-1:0] shift_reg;
    logic [1:0]           sync_pipe;   // [0] metastable stage, [1] usable
    logic                 sin_s;
    logic                 word_done;   // stop bit good; output stage decides next clk
`ifdef PARITY_CHECK_EN
    logic                 par_bad;
`endif

    assign sin_s = sync_pipe[1];

    // Two-flop synchronizer; resets to the idle line level so a reset never
    // looks like a start edge.
    always_ff @(posedge clk) begin
        if (reset) sync_pipe <= 2'b11;
        else       sync_pipe <= {sync_pipe[0], serial_in};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            tick_cnt  <= '0;
            bit_cnt   <= '0;
            shift_reg <= '0;
            word_done <= 1'b0;
            frame_err <= 1'b0;
`ifdef PARITY_CHECK_EN
            par_bad   <= 1'b0;
`endif
        end else begin
            word_done <= 1'b0;
            frame_err <= 1'b0;
            if (sample_tick) begin
                case (state)
                    S_IDLE: begin
                        if (!sin_s) begin
                            state    <= S_START;
                            tick_cnt <= '0;
                        end
                    end
                    S_START: begin
                        if (tick_cnt == HALF_LAST) begin
                            tick_cnt <= '0;
                            bit_cnt  <= '0;
                            // High at mid start bit means it was a glitch.
                            state    <= sin_s ? S_IDLE : S_DATA;
                        end else begin
                            tick_cnt <= tick_cnt + TW'(1);
                        end
                    end
                    S_DATA: begin
                        if (tick_cnt == BIT_LAST) begin
                            tick_cnt  <= '0;
                            shift_reg <= {shift_reg[DATA_BITS-2:0], sin_s};
                            if (bit_cnt == DATA_LAST) begin
                                bit_cnt <= '0;
`ifdef PARITY_CHECK_EN
                                state   <= S_PARITY;
`else
                                state   <= S_STOP;
`endif
                            end else begin
                                bit_cnt <= bit_cnt + BW'(1);
                            end
                        end else begin
                            tick_cnt <= tick_cnt + TW'(1);
                        end
                    end
`ifdef PARITY_CHECK_EN
                    S_PARITY: begin
                        if (tick_cnt == BIT_LAST) begin
                            tick_cnt <= '0;
                            // Even parity: data plus parity bit has an even count of ones.
                            par_bad  <= ^{shift_reg, sin_s};
                            state    <= S_STOP;
                        end else begin
                            tick_cnt <= tick_cnt + TW'(1);
                        end
                    end
`endif
                    S_STOP: begin
                        if (tick_cnt == BIT_LAST) begin
                            tick_cnt <= '0;
                            if (sin_s) begin
                                word_done <= 1'b1;
                                state     <= S_IDLE;
                            end else begin
                                frame_err <= 1'b1;
                                state     <= S_BREAK;
                            end
                        end else begin
                            tick_cnt <= tick_cnt + TW'(1);
                        end
                    end
                    S_BREAK: begin
                        // Held-low line must return high before a new start is accepted.
                        if (sin_s) state <= S_IDLE;
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

    // Output stage runs every clk, independent of sample_tick.
    always_ff @(posedge clk) begin
        if (reset) begin
            data_out   <= '0;
            data_valid <= 1'b0;
            overrun    <= 1'b0;
`ifdef PARITY_CHECK_EN
            parity_err <= 1'b0;
`endif
        end else begin
            overrun <= 1'b0;
`ifdef PARITY_CHECK_EN
            parity_err <= 1'b0;
`endif
            if (data_valid && data_ready) data_valid <= 1'b0;
            if (word_done) begin
`ifdef PARITY_CHECK_EN
                if (par_bad) begin
                    parity_err <= 1'b1;
                end else
`endif
                if (!data_valid || data_ready) begin
                    data_out   <= shift_reg;
                    data_valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_serial_rx_frame.sv
`timescale 1ns/1ps
module tb_serial_rx_frame;

    localparam int OS = 16;
    localparam int DB = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          sample_tick = 1'b1;
    logic          serial_in = 1'b1;
    logic          data_ready = 1'b1;
    logic [DB-1:0] data_out;
    logic          data_valid;
    logic          frame_err;
    logic          overrun;
`ifdef PARITY_CHECK_EN
    logic          parity_err;
`endif

    serial_rx_frame #(.OVERSAMPLE(OS), .DATA_BITS(DB)) dut (
        .clk        (clk),
        .reset      (reset),
        .sample_tick(sample_tick),
        .serial_in  (serial_in),
        .data_out   (data_out),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .frame_err  (frame_err),
        .overrun    (overrun)
`ifdef PARITY_CHECK_EN
        ,
        .parity_err (parity_err)
`endif
    );

    always #5 clk = ~clk;

    // sample_tick generator: one pulse every tick_div clks
    int tick_div = 1;
    int tick_ph  = 0;
    always @(posedge clk) begin
        #1;
        tick_ph     = (tick_ph >= tick_div - 1) ? 0 : tick_ph + 1;
        sample_tick = (tick_ph == 0);
    end

    // Observer: records what the DUT emits; all judging happens in the main sequence.
    int            n_vclk = 0, n_ferr = 0, n_ovr = 0, n_perr = 0, n_stab = 0;
    logic [DB-1:0] got_q[$];
    logic          pv = 1'b0, phs = 1'b0;
    logic [DB-1:0] pout = '0;
    always @(negedge clk) begin
        if (!reset) begin
            if (data_valid) n_vclk++;
            if (frame_err)  n_ferr++;
            if (overrun)    n_ovr++;
`ifdef PARITY_CHECK_EN
            if (parity_err) n_perr++;
`endif
            if (data_valid && data_ready) got_q.push_back(data_out);
            if (pv && !phs && data_valid && data_out !== pout) n_stab++;
        end
        pv   = data_valid;
        phs  = data_valid && data_ready;
        pout = data_out;
    end

    // Reference model: outcome of each frame from the framing rules alone.
    logic [DB-1:0] exp_q[$];
    int            exp_ferr = 0, exp_ovr = 0, exp_perr = 0;
    logic          m_hold = 1'b0;
    logic [DB-1:0] m_held = '0;

    task automatic model_frame(input logic [DB-1:0] d, input logic stop, input logic pflip);
        if (!stop)                      exp_ferr++;
        else if (pflip)                 exp_perr++;
        else if (m_hold && !data_ready) exp_ovr++;
        else if (data_ready)            exp_q.push_back(d);
        else begin
            m_hold = 1'b1;
            m_held = d;
        end
    endtask

    task automatic model_release();
        if (m_hold) exp_q.push_back(m_held);
        m_hold = 1'b0;
    endtask

    int checks = 0, errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    int bit_clks = OS;

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic hold(input logic v, input int n);
        serial_in = v;
        wait_clks(n);
    endtask

    task automatic send_frame(input logic [DB-1:0] d, input logic stop, input logic pflip);
        hold(1'b0, bit_clks);
        for (int i = DB - 1; i >= 0; i--) hold(d[i], bit_clks);
`ifdef PARITY_CHECK_EN
        hold((^d) ^ pflip, bit_clks);
`endif
        hold(stop, bit_clks);
        model_frame(d, stop, pflip);
    endtask

    task automatic check_words(input string tag);
        chk({tag, "_count"}, got_q.size(), exp_q.size());
        while (got_q.size() > 0 && exp_q.size() > 0)
            chk({tag, "_word"}, got_q.pop_front(), exp_q.pop_front());
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic check_flags(input string tag);
        chk({tag, "_frame_err"}, n_ferr, exp_ferr);
        chk({tag, "_overrun"},   n_ovr,  exp_ovr);
        chk({tag, "_parity_err"}, n_perr, exp_perr);
    endtask

    initial begin
        int v0;
        int nrand;
        logic [DB-1:0] d;

        // Reset state
        wait_clks(3);
        @(negedge clk);
        chk("rst_data_out", data_out, 0);
        chk("rst_valid", data_valid, 0);
        chk("rst_frame_err", frame_err, 0);
        chk("rst_overrun", overrun, 0);
        wait_clks(1);
        reset = 1'b0;
        hold(1'b1, 20);

        // 0xA5, consumer ready: one word, valid for exactly one clk
        v0 = n_vclk;
        send_frame(8'hA5, 1'b1, 1'b0);
        wait_clks(8);
        chk("a5_valid_clks", n_vclk - v0, 1);
        check_words("a5");
        check_flags("a5");

        // 4-clk low glitch on idle line, then a real frame must decode cleanly
        v0 = n_vclk;
        hold(1'b0, 4);
        hold(1'b1, 12);
        chk("glitch_no_valid", n_vclk - v0, 0);
        check_flags("glitch");
        d = 8'($urandom_range(0, 255));
        send_frame(d, 1'b1, 1'b0);
        wait_clks(8);
        check_words("post_glitch");

        // Bad stop bit then held-low line: single frame_err, no restart
        v0 = n_vclk;
        send_frame(8'h3C, 1'b0, 1'b0);
        hold(1'b0, 40);
        chk("brk_ferr_40", n_ferr, exp_ferr);
        hold(1'b0, 140);
        chk("brk_ferr_180", n_ferr, exp_ferr);
        chk("brk_no_valid", n_vclk - v0, 0);
        hold(1'b1, 32);
        send_frame(8'h81, 1'b1, 1'b0);
        wait_clks(8);
        check_words("after_break");
        check_flags("after_break");

        // Randomized bytes with random idle gaps (including back-to-back)
        v0 = n_vclk;
        nrand = 12;
        for (int k = 0; k < nrand; k++) begin
            hold(1'b1, $urandom_range(0, 20));
            send_frame(8'($urandom_range(0, 255)), 1'b1, 1'b0);
        end
        wait_clks(8);
        chk("rand_valid_clks", n_vclk - v0, nrand);
        check_words("rand");
        check_flags("rand");

        // Overrun: consumer stalled, two frames back-to-back
        data_ready = 1'b0;
        send_frame(8'h11, 1'b1, 1'b0);
        send_frame(8'h22, 1'b1, 1'b0);
        wait_clks(8);
        chk("ovr_valid_held", data_valid, 1);
        chk("ovr_data_held", data_out, 8'h11);
        check_flags("ovr");
        data_ready = 1'b1;
        model_release();
        wait_clks(3);
        chk("ovr_valid_drop", data_valid, 0);
        check_words("ovr");

        // Reset in the middle of 0xFF data bits
        hold(1'b1, 20);
        hold(1'b0, bit_clks);
        hold(1'b1, 3 * bit_clks);
        reset = 1'b1;
        wait_clks(1);
        @(negedge clk);
        chk("midrst_data_out", data_out, 0);
        chk("midrst_valid", data_valid, 0);
        chk("midrst_flags", {frame_err, overrun}, 0);
        wait_clks(1);
        reset = 1'b0;
        hold(1'b1, 6 * bit_clks + 20);
        chk("postrst_data_out", data_out, 0);
        chk("postrst_valid", data_valid, 0);
        check_words("midrst");
        send_frame(8'h5A, 1'b1, 1'b0);
        wait_clks(8);
        check_words("after_rst");
        check_flags("after_rst");

        // Sparse ticks: one every 3 clks, 48 clk per bit
        tick_div = 3;
        bit_clks = 3 * OS;
        hold(1'b1, 30);
        send_frame(8'hC3, 1'b1, 1'b0);
        wait_clks(8);
        check_words("tick3");
`ifdef PARITY_CHECK_EN
        v0 = n_vclk;
        hold(1'b1, 30);
        send_frame(8'hC3, 1'b1, 1'b1);
        wait_clks(8);
        chk("par_no_valid", n_vclk - v0, 0);
        check_words("par_bad");
`endif
        check_flags("tick3");

        chk("data_out_stable", n_stab, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
